// File: rtl/hazard_fwd_ctrl.sv
// Hazard and forwarding control for the 5-stage MIPS pipeline: shadows dst/Tnew
// through E/M/W and produces the forwarding mux selects plus the pipeline stall.
module hazard_fwd_ctrl #(
  parameter int unsigned TNEW_W = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              d_valid,
  input  logic [4:0]        d_rs,
  input  logic [4:0]        d_rt,
  input  logic [TNEW_W-1:0] d_tuse_rs,
  input  logic [TNEW_W-1:0] d_tuse_rt,
  input  logic [4:0]        d_dst,
  input  logic [TNEW_W-1:0] d_tnew,
  input  logic              d_is_md,
  input  logic              md_busy,
  output logic              stall,
  output logic [1:0]        fwd_d_rs_sel,
  output logic [1:0]        fwd_d_rt_sel,
  output logic [1:0]        fwd_e_rs_sel,
  output logic [1:0]        fwd_e_rt_sel,
  output logic              fwd_m_rt_sel
);

  typedef logic [4:0]        reg_t;
  typedef logic [TNEW_W-1:0] tnew_t;

  localparam tnew_t TUSE_NONE = '1;

  reg_t  dst_e, dst_m, dst_w;
  tnew_t tnew_e, tnew_m, tnew_w;
  reg_t  rs_e, rt_e, rt_m;

  logic haz_rs, haz_rt;

  function automatic tnew_t sat_dec(input tnew_t t);
    return (t == '0) ? '0 : t - tnew_t'(1);
  endfunction

  // D-stage select: the newest matching stage decides; a not-yet-ready match forwards nothing.
  function automatic logic [1:0] d_sel(input reg_t src,
                                       input reg_t de, input reg_t dm, input reg_t dw,
                                       input tnew_t te, input tnew_t tm, input tnew_t tw);
    logic [1:0] sel;
    sel = 2'b00;
    if (src != '0) begin
      if (src == de)      sel = (te == '0) ? 2'b01 : 2'b00;
      else if (src == dm) sel = (tm == '0) ? 2'b10 : 2'b00;
      else if (src == dw) sel = (tw == '0) ? 2'b11 : 2'b00;
    end
    return sel;
  endfunction

  // Operand hazard: newest producer of src will not be ready by the time it is used.
  function automatic logic reg_hazard(input reg_t src, input tnew_t tuse,
                                      input reg_t de, input reg_t dm, input reg_t dw,
                                      input tnew_t te, input tnew_t tm, input tnew_t tw);
    logic haz;
    haz = 1'b0;
    if ((src != '0) && (tuse != TUSE_NONE)) begin
      if (src == de)      haz = (te > tuse);
      else if (src == dm) haz = (tm > tuse);
      else if (src == dw) haz = (tw > tuse);
    end
    return haz;
  endfunction

  // E-stage select: an unready M match blocks the older W result.
  function automatic logic [1:0] e_sel(input reg_t src, input reg_t dm, input reg_t dw,
                                       input tnew_t tm);
    logic [1:0] sel;
    sel = 2'b00;
    if (src != '0) begin
      if (src == dm)      sel = (tm == '0) ? 2'b01 : 2'b00;
      else if (src == dw) sel = 2'b10;
    end
    return sel;
  endfunction

  always_comb begin
    haz_rs       = 1'b0;
    haz_rt       = 1'b0;
    stall        = 1'b0;
    fwd_d_rs_sel = 2'b00;
    fwd_d_rt_sel = 2'b00;
    fwd_e_rs_sel = 2'b00;
    fwd_e_rt_sel = 2'b00;
    fwd_m_rt_sel = 1'b0;

    haz_rs = d_valid && reg_hazard(d_rs, d_tuse_rs, dst_e, dst_m, dst_w, tnew_e, tnew_m, tnew_w);
    haz_rt = d_valid && reg_hazard(d_rt, d_tuse_rt, dst_e, dst_m, dst_w, tnew_e, tnew_m, tnew_w);
    // MD term is not derived from shadow state, so reset must mask it directly.
    stall  = reset_n && (haz_rs || haz_rt || (d_is_md && md_busy));

    fwd_d_rs_sel = d_sel(d_rs, dst_e, dst_m, dst_w, tnew_e, tnew_m, tnew_w);
    fwd_d_rt_sel = d_sel(d_rt, dst_e, dst_m, dst_w, tnew_e, tnew_m, tnew_w);
    fwd_e_rs_sel = e_sel(rs_e, dst_m, dst_w, tnew_m);
    fwd_e_rt_sel = e_sel(rt_e, dst_m, dst_w, tnew_m);
    fwd_m_rt_sel = (rt_m != '0) && (rt_m == dst_w);
  end

  // Shadow pipeline; a stalled or invalid D enters E as an all-zero bubble.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dst_e  <= '0;
      tnew_e <= '0;
      rs_e   <= '0;
      rt_e   <= '0;
      dst_m  <= '0;
      tnew_m <= '0;
      rt_m   <= '0;
      dst_w  <= '0;
      tnew_w <= '0;
    end else begin
      dst_w  <= dst_m;
      tnew_w <= sat_dec(tnew_m);
      dst_m  <= dst_e;
      tnew_m <= sat_dec(tnew_e);
      rt_m   <= rt_e;
      if (d_valid && !stall) begin
        dst_e  <= d_dst;
        tnew_e <= d_tnew;
        rs_e   <= d_rs;
        rt_e   <= d_rt;
      end else begin
        dst_e  <= '0;
        tnew_e <= '0;
        rs_e   <= '0;
        rt_e   <= '0;
      end
    end
  end

endmodule
